hex_pair_display_driver: RTL and testbench



---
 rtl/hex_pair_display_driver.sv | 127 ++++++++++++
 tb/tb_hex_pair_display_driver.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hex_pair_display_driver.sv
// Two-digit seven-segment driver for the HEX5/HEX4 PIO word: captures the word,
// then applies blink, brightness PWM and leading-zero blanking to active-low segments.
module hex_pair_display_driver #(
  parameter int BLINK_DIV = 25000000,
  parameter int PWM_DIV   = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] data_in,
  output logic [6:0]  hex5_n,
  output logic [6:0]  hex4_n,
  output logic        update
);

  localparam int BW = $clog2(BLINK_DIV);
  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  localparam logic [PW-1:0] PRE_MAX   = PW'(PWM_DIV - 1);
  localparam logic [6:0]    BLANK     = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [12:0]   cap_p1;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [PW-1:0] pwm_pre;
  logic [1:0]    pwm_slot;

  logic       chg;
  logic       en, blink_en, lz_blank, lit, show;
  logic [1:0] bright;
  logic [6:0] hex5_nxt, hex4_nxt;

  // Reserved bits [15:13] are deliberately never looked at.
  logic reserved_unused;
  assign reserved_unused = ^data_in[15:13];

  assign chg      = (data_in[12:0] != cap_p1);
  assign en       = cap_p1[8];
  assign blink_en = cap_p1[9];
  assign lz_blank = cap_p1[10];
  assign bright   = cap_p1[12:11];
  assign lit      = (pwm_slot <= bright);
  assign show     = en & lit & (blink_phase | ~blink_en);

  always_comb begin
    hex5_nxt = BLANK;
    hex4_nxt = BLANK;
    if (show) begin
      hex4_nxt = seg_decode(cap_p1[3:0]);
      if (!(lz_blank && cap_p1[7:4] == 4'h0))
        hex5_nxt = seg_decode(cap_p1[7:4]);
    end
  end

  // Stage 1: capture word and flag changes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap_p1 <= '0;
      update <= 1'b0;
    end else begin
      cap_p1 <= data_in[12:0];
      update <= chg;
    end
  end

  // A new word restarts the blink cycle in its on phase, even at terminal count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (!(en && blink_en) || chg) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwm_pre  <= '0;
      pwm_slot <= 2'd0;
    end else if (pwm_pre == PRE_MAX) begin
      pwm_pre  <= '0;
      pwm_slot <= pwm_slot + 2'd1;
    end else begin
      pwm_pre  <= pwm_pre + 1'b1;
    end
  end

  // Stage 2: registered segment drives
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hex5_n <= BLANK;
      hex4_n <= BLANK;
    end else begin
      hex5_n <= hex5_nxt;
      hex4_n <= hex4_nxt;
    end
  end

endmodule

// File: tb/tb_hex_pair_display_driver.sv
// Directed bench for hex_pair_display_driver with BLINK_DIV=4 and PWM_DIV=1.
module tb_hex_pair_display_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] data_in;
  logic [6:0]  hex5_n;
  logic [6:0]  hex4_n;
  logic        update;

  int n_pass  = 0;
  int n_total = 0;
  int lit_cnt;

  hex_pair_display_driver #(.BLINK_DIV(4), .PWM_DIV(1)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .data_in(data_in),
    .hex5_n (hex5_n),
    .hex4_n (hex4_n),
    .update (update)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    data_in = 16'h1F3A;
    repeat (3) step();
    chk("rst_hex5", 16'(hex5_n), 16'h7F);
    chk("rst_hex4", 16'(hex4_n), 16'h7F);
    chk("rst_update", 16'(update), 16'h0);

    reset_n = 1'b1;
    step();
    chk("rel1_update", 16'(update), 16'h1);
    chk("rel1_hex5", 16'(hex5_n), 16'h7F);
    step();
    chk("rel2_hex5", 16'(hex5_n), 16'h30);
    chk("rel2_hex4", 16'(hex4_n), 16'h08);
    chk("rel2_update", 16'(update), 16'h0);

    // brightness 0: lit one slot in four
    data_in = 16'h0131;
    repeat (2) step();
    lit_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (hex4_n == 7'h79) lit_cnt++;
      step();
    end
    chk("pwm_b0_lit", 16'(lit_cnt), 16'd2);

    data_in = 16'h1931;
    repeat (2) step();
    lit_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (hex4_n == 7'h79 && hex5_n == 7'h30) lit_cnt++;
      step();
    end
    chk("pwm_b3_lit", 16'(lit_cnt), 16'd8);

    data_in = 16'h1D05;
    repeat (2) step();
    chk("lz05_hex5", 16'(hex5_n), 16'h7F);
    chk("lz05_hex4", 16'(hex4_n), 16'h12);
    data_in = 16'h1D00;
    repeat (2) step();
    chk("lz00_hex5", 16'(hex5_n), 16'h7F);
    chk("lz00_hex4", 16'(hex4_n), 16'h40);
    data_in = 16'h1900;
    repeat (2) step();
    chk("nolz_hex5", 16'(hex5_n), 16'h40);
    chk("nolz_hex4", 16'(hex4_n), 16'h40);

    data_in = 16'h9900;
    step();
    chk("rsv_update", 16'(update), 16'h0);
    step();
    chk("rsv_hex5", 16'(hex5_n), 16'h40);
    chk("rsv_hex4", 16'(hex4_n), 16'h40);

    // blink: on after edges 2..5, off after 6..9
    data_in = 16'h1B42;
    step();
    chk("blink_update", 16'(update), 16'h1);
    for (int i = 2; i <= 8; i++) begin
      step();
      chk($sformatf("blink_e%0d", i), 16'(hex4_n), (i <= 5) ? 16'h24 : 16'h7F);
    end
    data_in = 16'h1B43;
    step();
    chk("chg_tc_hex4", 16'(hex4_n), 16'h7F);
    chk("chg_tc_update", 16'(update), 16'h1);
    for (int i = 10; i <= 13; i++) begin
      step();
      chk($sformatf("newon_e%0d", i), 16'(hex4_n), 16'h30);
      if (i == 10) begin
        chk("newon_hex5", 16'(hex5_n), 16'h19);
        chk("newon_update", 16'(update), 16'h0);
      end
    end
    step();
    chk("newoff_e14", 16'(hex4_n), 16'h7F);

    data_in = 16'h1842;
    repeat (2) step();
    chk("dis_hex5", 16'(hex5_n), 16'h7F);
    chk("dis_hex4", 16'(hex4_n), 16'h7F);
    step();
    chk("dis_blink_cnt", 16'(dut.blink_cnt), 16'h0);
    chk("dis_blink_phase", 16'(dut.blink_phase), 16'h1);
    data_in = 16'h9842;
    step();
    chk("dis_rsv_update", 16'(update), 16'h0);
    step();
    chk("dis_rsv_hex4", 16'(hex4_n), 16'h7F);

    data_in = 16'h1B42;
    repeat (3) step();
    chk("pre_rst_lit", 16'(hex4_n), 16'h24);
    reset_n = 1'b0;
    step();
    chk("midrst_hex5", 16'(hex5_n), 16'h7F);
    chk("midrst_hex4", 16'(hex4_n), 16'h7F);
    chk("midrst_update", 16'(update), 16'h0);
    reset_n = 1'b1;
    step();
    chk("rerel_update", 16'(update), 16'h1);
    chk("rerel_hex4", 16'(hex4_n), 16'h7F);
    for (int i = 2; i <= 6; i++) begin
      step();
      chk($sformatf("rerel_e%0d", i), 16'(hex4_n), (i <= 5) ? 16'h24 : 16'h7F);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
